addr_gen: RTL and testbench
===========================

ADDR_GEN -- requirements
Module: addr_gen

Interface
- REQ-001 SHALL have parameter AW, default 16, address width (multiple of DW, min 2*DW).
- REQ-002 SHALL have parameter DW, default 8, data/byte width.
- REQ-003 SHALL have parameter RESET_VEC, default 16'hFFFC, PC value after reset.
- REQ-004 SHALL have ports, clock and reset first:
  - ph2  in  1  sole clock, rising edge.
  - resetb  in  1  asynchronous active-low reset.
  - cmd_valid  in  1  command offered.
  - cmd_ready  out  1  high only in IDLE.
  - cmd_op  in  3  operation code.
  - idx_in  in  DW  index value, sampled at cmd accept.
  - data_in  in  DW  memory read byte.
  - data_valid  in  1  data_in valid this cycle.
  - mem_rd  out  1  memory read request at address.
  - address  out  AW  bus address.
  - ea  out  AW  effective address result.
  - pc  out  AW  program counter.
  - done  out  1  one-cycle completion pulse.
  - page_cross  out  1  high with done if index/branch add carried into the high byte.
  - illegal  out  1  high with done for a reserved opcode.

Function
- REQ-005 Handshake SHALL be: accept when cmd_valid && cmd_ready; op and idx_in registered at accept.
- REQ-006 FSM states SHALL be IDLE, FETCH_LO, FETCH_HI, ADD_LO, FIX_HI, DONE; DONE drives done=1 and returns to IDLE next cycle.
- REQ-007 In FETCH_LO/FETCH_HI: mem_rd=1, address=pc; each data_valid cycle captures the byte, pc+1; no data_valid means the state holds indefinitely.
- REQ-008 Outside fetch states: mem_rd=0, address=ea.
- REQ-009 OP_INC(0) SHALL set pc+1 and go IDLE->DONE; done one cycle after accept.
- REQ-010 OP_ZP(1) SHALL fetch one byte; ea={0,byte}.
- REQ-011 OP_ZPX(2) SHALL compute ea={0,(byte+idx) mod 2^DW}: wraps within page zero, page_cross=0.
- REQ-012 OP_ABS(3) SHALL fetch lo then hi; ea={hi,lo}.
- REQ-013 OP_ABSX(4) SHALL do ABS then ADD_LO: lo+idx; on carry, FIX_HI increments the high part.
- REQ-014 OP_JMP(5) SHALL do ABS, then load pc=ea in DONE.
- REQ-015 OP_REL(6) SHALL fetch offset, sign-extend, pc=pc+offset (pc already past the offset byte), ea=new pc; page_cross when the high part changes.
- REQ-016 Opcode 7 SHALL be a no-op: done and illegal in the next cycle, pc unchanged.
- REQ-017 All pc/ea arithmetic SHALL wrap modulo 2^AW (FFFF+1=0000).
- REQ-018 cmd_valid while busy SHALL be ignored (not queued).

Reset
- REQ-019 On resetb low, asynchronously: state=IDLE, pc=RESET_VEC, ea=0, done=page_cross=illegal=mem_rd=0.
- REQ-020 Reset mid-operation SHALL abandon the command with no done pulse; cmd_ready=1 the first clock after release.

Configuration
- REQ-021 With macro ADDR_GEN_PAGE_PENALTY_EN defined, a carry SHALL insert the FIX_HI cycle (+1 latency).
- REQ-022 Without the macro, carry SHALL propagate within ADD_LO, FIX_HI is never entered, and page_cross is still reported.

Structure
- REQ-023 Package addr_gen_pkg SHALL hold the op enum, the state enum and the OP_* constants.
- REQ-024 Sub-module addr_gen_add SHALL be the byte adder (DW-bit a+b+cin, sum, cout), instantiated for lo and hi adds.

Verification
- REQ-025 Reset: RESET_VEC=FFFC, release -> pc=FFFC, cmd_ready=1, all flags 0.
- REQ-026 OP_ABSX, pc=0200, bytes F0,12, idx=20, data_valid each cycle -> ea=1310, page_cross=1, done 5 cycles after accept with the macro, 4 without; pc=0202.
- REQ-027 OP_REL, pc=10FE, offset 05 -> pc=1104, page_cross=1; offset FB at pc=1000 -> pc=0FFC, page_cross=1.
- REQ-028 OP_ZPX, byte FF, idx 02 -> ea=0001, page_cross=0.
- REQ-029 OP_INC at pc=FFFF -> pc=0000; opcode 7 -> illegal=1, pc unchanged.
- REQ-030 data_valid held low 3 cycles in FETCH_HI -> mem_rd stays 1 and address stable; resetb low there -> IDLE, no done.

Source files
------------

// File: rtl/addr_gen_pkg.sv
// addr_gen_pkg: shared opcode and FSM state definitions for the address generator.
package addr_gen_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_INC  = 3'd0,
    OP_ZP   = 3'd1,
    OP_ZPX  = 3'd2,
    OP_ABS  = 3'd3,
    OP_ABSX = 3'd4,
    OP_JMP  = 3'd5,
    OP_REL  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    ADD_LO,
    FIX_HI,
    DONE
  } state_e;

  // Opcodes whose operand is a full two-byte address.
  function automatic logic is_two_byte(input op_e op);
    return (op == OP_ABS) || (op == OP_ABSX) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/addr_gen_add.sv
// addr_gen_add: W-bit adder with carry in/out, used for the low and high address parts.
module addr_gen_add #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Plain ripple add; carry out is the extra top bit.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/addr_gen.sv
// addr_gen: 6502-style effective-address / program-counter sequencer.
// Optional macro ADDR_GEN_PAGE_PENALTY_EN: an indexed-absolute carry costs an
// extra FIX_HI cycle; otherwise the carry ripples into the high part in ADD_LO.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int unsigned    AW        = 16,
  parameter int unsigned    DW        = 8,
  parameter logic [AW-1:0]  RESET_VEC = 16'hFFFC
) (
  input  logic          ph2,
  input  logic          resetb,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] idx_in,
  input  logic [DW-1:0] data_in,
  input  logic          data_valid,
  output logic          mem_rd,
  output logic [AW-1:0] address,
  output logic [AW-1:0] ea,
  output logic [AW-1:0] pc,
  output logic          done,
  output logic          page_cross,
  output logic          illegal
);

  localparam int unsigned HW = AW - DW;

  state_e        state;
  op_e           op;
  logic [DW-1:0] idx;

  logic [DW-1:0] lo_a, lo_b, lo_sum;
  logic          lo_cout;
  logic [HW-1:0] hi_a, hi_b, hi_sum;
  logic          hi_cin;
  logic          unused_hi_cout;

  assign cmd_ready = (state == IDLE);
  assign address   = mem_rd ? pc : ea;

  // Operand select: REL adds the sign-extended offset to pc, indexed modes add idx to ea.
  always_comb begin
    lo_a = ea[DW-1:0];
    lo_b = idx;
    hi_a = ea[AW-1:DW];
    hi_b = '0;
    if (state == ADD_LO && op == OP_REL) begin
      lo_a = pc[DW-1:0];
      lo_b = ea[DW-1:0];
      hi_a = pc[AW-1:DW];
      hi_b = {HW{ea[DW-1]}};
    end
  end

  assign hi_cin = (state == FIX_HI) || ((state == ADD_LO) && lo_cout);

  addr_gen_add #(.W(DW)) u_add_lo (
    .a    (lo_a),
    .b    (lo_b),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  addr_gen_add #(.W(HW)) u_add_hi (
    .a    (hi_a),
    .b    (hi_b),
    .cin  (hi_cin),
    .sum  (hi_sum),
    .cout (unused_hi_cout)
  );

  // Command FSM with registered pc/ea, read strobe and completion flags.
  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      op         <= OP_INC;
      idx        <= '0;
      pc         <= RESET_VEC;
      ea         <= '0;
      mem_rd     <= 1'b0;
      done       <= 1'b0;
      page_cross <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      done       <= 1'b0;
      page_cross <= 1'b0;
      illegal    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op  <= op_e'(cmd_op);
            idx <= idx_in;
            case (op_e'(cmd_op))
              OP_INC: begin
                pc    <= pc + 1'b1;
                state <= DONE;
                done  <= 1'b1;
              end
              OP_RSVD: begin
                state   <= DONE;
                done    <= 1'b1;
                illegal <= 1'b1;
              end
              default: begin
                state  <= FETCH_LO;
                mem_rd <= 1'b1;
              end
            endcase
          end
        end
        FETCH_LO: begin
          if (data_valid) begin
            pc <= pc + 1'b1;
            ea <= AW'(data_in);
            if (is_two_byte(op)) begin
              state <= FETCH_HI;
            end else if (op == OP_ZP) begin
              state  <= DONE;
              done   <= 1'b1;
              mem_rd <= 1'b0;
            end else begin
              state  <= ADD_LO;
              mem_rd <= 1'b0;
            end
          end
        end
        FETCH_HI: begin
          if (data_valid) begin
            pc          <= pc + 1'b1;
            ea[AW-1:DW] <= HW'(data_in);
            mem_rd      <= 1'b0;
            if (op == OP_ABSX) begin
              state <= ADD_LO;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        ADD_LO: begin
          case (op)
            OP_ZPX: begin
              ea    <= AW'(lo_sum);
              state <= DONE;
              done  <= 1'b1;
            end
            OP_ABSX: begin
              ea[DW-1:0] <= lo_sum;
`ifdef ADDR_GEN_PAGE_PENALTY_EN
              if (lo_cout) begin
                state <= FIX_HI;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
`else
              ea[AW-1:DW] <= hi_sum;
              page_cross  <= lo_cout;
              state       <= DONE;
              done        <= 1'b1;
`endif
            end
            OP_REL: begin
              pc         <= {hi_sum, lo_sum};
              ea         <= {hi_sum, lo_sum};
              page_cross <= (hi_sum != pc[AW-1:DW]);
              state      <= DONE;
              done       <= 1'b1;
            end
            default: begin
              state <= DONE;
              done  <= 1'b1;
            end
          endcase
        end
        // Only reached after a low-byte carry, so the crossing is certain.
        FIX_HI: begin
          ea[AW-1:DW] <= hi_sum;
          page_cross  <= 1'b1;
          state       <= DONE;
          done        <= 1'b1;
        end
        DONE: begin
          if (op == OP_JMP) begin
            pc <= ea;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_gen.sv
// tb_addr_gen: directed bench for addr_gen with an arithmetic reference model.
module tb_addr_gen;
  import addr_gen_pkg::*;

`ifdef ADDR_GEN_PAGE_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam logic [15:0] RV = 16'hFFFC;

  logic        ph2 = 1'b0;
  logic        resetb = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [7:0]  idx_in = '0;
  logic [7:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        cmd_ready, mem_rd, done, page_cross, illegal;
  logic [15:0] address, ea, pc;

  addr_gen #(.AW(16), .DW(8), .RESET_VEC(16'hFFFC)) dut (
    .ph2        (ph2),
    .resetb     (resetb),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .idx_in     (idx_in),
    .data_in    (data_in),
    .data_valid (data_valid),
    .mem_rd     (mem_rd),
    .address    (address),
    .ea         (ea),
    .pc         (pc),
    .done       (done),
    .page_cross (page_cross),
    .illegal    (illegal)
  );

  always #5 ph2 = ~ph2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model state and per-command expectations.
  logic [15:0] m_pc, m_ea;
  logic [15:0] e_pc, e_ea;
  logic        e_pcross, e_ill;
  int          e_lat;

  bit   chk_en = 1'b0;
  bit   exp_ready = 1'b1;
  bit   exp_done = 1'b0;
  int   cyc = 0;
  logic [15:0] cap_ea;
  logic        cap_pcross, cap_ill;
  int          cap_lat;

  task automatic predict(input logic [2:0] op, input logic [7:0] idx,
                         input logic [7:0] b0, input logic [7:0] b1);
    int base, p, off;
    e_ill = 1'b0; e_pcross = 1'b0; e_ea = m_ea; e_pc = m_pc; e_lat = 1;
    case (op)
      3'd0: begin e_pc = 16'((int'(m_pc) + 1) % 65536); e_lat = 1; end
      3'd1: begin e_ea = {8'h00, b0}; e_pc = 16'((int'(m_pc) + 1) % 65536); e_lat = 2; end
      3'd2: begin e_ea = 16'((int'(b0) + int'(idx)) % 256); e_pc = 16'((int'(m_pc) + 1) % 65536); e_lat = 3; end
      3'd3: begin e_ea = {b1, b0}; e_pc = 16'((int'(m_pc) + 2) % 65536); e_lat = 3; end
      3'd4: begin
        base = int'(b1) * 256 + int'(b0);
        e_ea = 16'((base + int'(idx)) % 65536);
        e_pcross = (int'(e_ea) / 256) != int'(b1);
        e_pc = 16'((int'(m_pc) + 2) % 65536);
        e_lat = (e_pcross && PEN) ? 5 : 4;
      end
      3'd5: begin e_ea = {b1, b0}; e_pc = {b1, b0}; e_lat = 3; end
      3'd6: begin
        p = (int'(m_pc) + 1) % 65536;
        off = (b0 >= 8'h80) ? int'(b0) - 256 : int'(b0);
        e_ea = 16'((p + off + 65536) % 65536);
        e_pc = e_ea;
        e_pcross = (int'(e_ea) / 256) != (p / 256);
        e_lat = 3;
      end
      default: begin e_ill = 1'b1; e_lat = 1; end
    endcase
  endtask

  // Cycle-by-cycle comparison against the model's handshake/done timeline.
  always @(negedge ph2) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, exp_ready);
      chk("done", done, exp_done);
      if (exp_done) begin
        chk("ea", ea, e_ea);
        chk("page_cross", page_cross, e_pcross);
        chk("illegal", illegal, e_ill);
        cap_ea = ea; cap_pcross = page_cross; cap_ill = illegal; cap_lat = cyc;
      end else begin
        chk("flags_quiet", {page_cross, illegal}, 2'b00);
      end
    end
  end

  task automatic run(input logic [2:0] op, input logic [7:0] idx, input logic [7:0] b0,
                     input logic [7:0] b1, input int stall, input bit poke);
    int nb, tot;
    nb = (op == 3'd3 || op == 3'd4 || op == 3'd5) ? 2 :
         (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 1 : 0;
    predict(op, idx, b0, b1);
    tot = e_lat + ((nb == 2) ? stall : 0);
    @(posedge ph2); #1;
    cmd_valid = 1'b1; cmd_op = op; idx_in = idx;
    @(posedge ph2); #1;
    exp_ready = 1'b0;
    cmd_valid = poke;
    cmd_op = 3'd0;
    idx_in = 8'h55;
    for (int k = 1; k <= tot; k++) begin
      cyc = k;
      exp_done = (k == tot);
      if (nb >= 1 && k == 1) begin
        data_valid = 1'b1; data_in = b0;
      end else if (nb == 2 && k == 2 + stall) begin
        data_valid = 1'b1; data_in = b1;
      end else begin
        data_valid = 1'b0; data_in = 8'($urandom);
      end
      if (nb == 2 && k >= 2 && k < 2 + stall) begin
        chk("stall_mem_rd", mem_rd, 1'b1);
        chk("stall_address", address, 16'((int'(m_pc) + 1) % 65536));
      end
      if (k == tot) cmd_valid = 1'b0;
      @(posedge ph2); #1;
    end
    exp_done = 1'b0;
    exp_ready = 1'b1;
    data_valid = 1'b0;
    chk("pc_after", pc, e_pc);
    m_pc = e_pc;
    m_ea = e_ea;
  endtask

  initial begin
    #1 resetb = 1'b0;
    #2;
    chk("rst_async_pc", pc, RV);
    chk("rst_async_ea", ea, 16'h0000);
    chk("rst_async_flags", {done, page_cross, illegal, mem_rd}, 4'b0000);
    repeat (2) @(posedge ph2);
    #1 resetb = 1'b1;
    #1;
    chk("rst_pc", pc, 16'hFFFC);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_flags", {done, page_cross, illegal, mem_rd}, 4'b0000);
    m_pc = RV; m_ea = '0;
    chk_en = 1'b1;

    run(3'd5, 8'h00, 8'h00, 8'h02, 0, 0);
    chk("lit_jmp_pc", pc, 16'h0200);
    run(3'd4, 8'h20, 8'hF0, 8'h12, 0, 0);
    chk("lit_absx_ea", cap_ea, 16'h1310);
    chk("lit_absx_pcross", cap_pcross, 1'b1);
    chk("lit_absx_lat", cap_lat, PEN ? 5 : 4);
    chk("lit_absx_pc", pc, 16'h0202);
    run(3'd4, 8'h05, 8'hF0, 8'h12, 0, 1);
    chk("lit_absx_nc_ea", cap_ea, 16'h12F5);
    chk("lit_absx_nc_lat", cap_lat, 4);
    chk("lit_busy_ignored_pc", pc, 16'h0204);

    run(3'd5, 8'h00, 8'hFE, 8'h10, 0, 0);
    run(3'd6, 8'h00, 8'h05, 8'h00, 0, 0);
    chk("lit_rel_fwd_pc", pc, 16'h1104);
    chk("lit_rel_fwd_pcross", cap_pcross, 1'b1);
    run(3'd5, 8'h00, 8'h00, 8'h10, 0, 0);
    run(3'd6, 8'h00, 8'hFB, 8'h00, 0, 0);
    chk("lit_rel_back_pc", pc, 16'h0FFC);
    chk("lit_rel_back_pcross", cap_pcross, 1'b1);
    run(3'd6, 8'h00, 8'h02, 8'h00, 0, 0);

    run(3'd2, 8'h02, 8'hFF, 8'h00, 0, 0);
    chk("lit_zpx_ea", cap_ea, 16'h0001);
    chk("lit_zpx_pcross", cap_pcross, 1'b0);
    run(3'd1, 8'h00, 8'h80, 8'h00, 0, 0);
    chk("lit_zp_ea", cap_ea, 16'h0080);
    run(3'd3, 8'h00, 8'h34, 8'h12, 3, 0);
    chk("lit_abs_stall_ea", cap_ea, 16'h1234);
    chk("lit_abs_stall_lat", cap_lat, 6);

    run(3'd5, 8'h00, 8'h00, 8'h03, 0, 0);
    run(3'd4, 8'h01, 8'hFF, 8'hFF, 0, 0);
    chk("lit_absx_wrap_ea", cap_ea, 16'h0000);

    run(3'd5, 8'h00, 8'hFF, 8'hFF, 0, 0);
    run(3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
    chk("lit_inc_wrap_pc", pc, 16'h0000);
    chk("lit_inc_lat", cap_lat, 1);
    run(3'd7, 8'h00, 8'h00, 8'h00, 0, 0);
    chk("lit_rsvd_ill", cap_ill, 1'b1);
    chk("lit_rsvd_pc", pc, 16'h0000);

    // Abandon an ABS stalled in FETCH_HI by asserting reset there.
    @(posedge ph2); #1;
    cmd_valid = 1'b1; cmd_op = 3'd3;
    @(posedge ph2); #1;
    exp_ready = 1'b0; cmd_valid = 1'b0;
    data_valid = 1'b1; data_in = 8'hAA;
    @(posedge ph2); #1;
    data_valid = 1'b0;
    @(posedge ph2); #1;
    chk("midrst_mem_rd", mem_rd, 1'b1);
    chk("midrst_address", address, 16'h0001);
    chk_en = 1'b0;
    resetb = 1'b0;
    #1;
    chk("midrst_async_ready", cmd_ready, 1'b1);
    chk("midrst_async_pc", pc, RV);
    chk("midrst_async_mem_rd", mem_rd, 1'b0);
    @(posedge ph2); #1;
    resetb = 1'b1;
    exp_ready = 1'b1; exp_done = 1'b0;
    m_pc = RV; m_ea = '0;
    chk_en = 1'b1;
    chk("midrst_ready", cmd_ready, 1'b1);
    chk("midrst_no_done", done, 1'b0);
    repeat (3) @(posedge ph2);
    #1;
    chk("midrst_pc_hold", pc, 16'hFFFC);

    run(3'd0, 8'h00, 8'h00, 8'h00, 0, 0);
    chk("lit_post_rst_inc", pc, 16'hFFFD);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
